// File: rtl/pwm_duty_sequencer.sv
// Plays a programmed table of pulse_width values into the PWM generator, one step per
// hold_frames frames, switching only at frame_tick so no pulse is ever truncated.
module pwm_duty_sequencer #(
    parameter int                DEPTH   = 8,
    parameter int                PW_W    = 4,
    parameter int                HOLD_W  = 8,
    parameter logic [PW_W-1:0]   PW_IDLE = '0
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               stop,
    input  logic               loop_en,
    input  logic [3:0]         seq_len,
    input  logic [HOLD_W-1:0]  hold_frames,
    input  logic               wr_en,
    input  logic [2:0]         wr_addr,
    input  logic [PW_W-1:0]    wr_data,
    output logic [PW_W-1:0]    pulse_width,
    output logic [2:0]         step_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int          IDX_W   = 3;
    localparam int          LEN_W   = 4;
    localparam logic [3:0]  LEN_MAX = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_RUN      = 2'd2,
        S_STOPPING = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PW_W-1:0]    pw_q, pw_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               loop_q, loop_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [PW_W-1:0]    tbl_q [DEPTH];
    logic               tbl_we;

    logic               len_ok;
    logic               last_step;
    logic [IDX_W-1:0]   idx_next;

    assign len_ok    = (seq_len != '0) && (seq_len <= LEN_MAX);
    assign last_step = (LEN_W'(idx_q) == len_q - LEN_W'(1));
    assign idx_next  = idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        pw_d       = pw_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        hold_d     = hold_q;
        len_d      = len_q;
        loop_d     = loop_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        tbl_we     = 1'b0;

        if (wr_en) begin
            if (state_q == S_IDLE) tbl_we = 1'b1;
            else                   err_d  = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                // stop outranks start even though stop itself does nothing here
                if (start && !stop) begin
                    if (len_ok) begin
                        len_d   = seq_len;
                        loop_d  = loop_en;
                        hold_d  = (hold_frames == '0) ? HOLD_W'(1) : hold_frames;
                        state_d = S_ARM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                if (stop) begin
                    state_d = S_STOPPING;
                end else if (frame_tick) begin
                    pw_d       = tbl_q[0];
                    idx_d      = '0;
                    hold_cnt_d = hold_q - HOLD_W'(1);
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_STOPPING;
                end else if (frame_tick) begin
                    if (hold_cnt_q != '0) begin
                        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                    end else if (!last_step) begin
                        idx_d      = idx_next;
                        pw_d       = tbl_q[idx_next];
                        hold_cnt_d = hold_q - HOLD_W'(1);
                    end else if (loop_q) begin
                        idx_d      = '0;
                        pw_d       = tbl_q[0];
                        hold_cnt_d = hold_q - HOLD_W'(1);
                    end else begin
                        idx_d   = '0;
                        pw_d    = PW_IDLE;
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_STOPPING: begin
                if (frame_tick) begin
                    pw_d    = PW_IDLE;
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pw_q       <= PW_IDLE;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            hold_q     <= HOLD_W'(1);
            len_q      <= LEN_W'(1);
            loop_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            pw_q       <= pw_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            done_q     <= done_d;
            err_q      <= err_d;
            if (tbl_we) tbl_q[wr_addr] <= wr_data;
        end
    end

    assign pulse_width = pw_q;
    assign step_idx    = idx_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign err         = err_q;

endmodule
